sseg_capture: RTL and testbench

Seven-segment bus receiver: monitors the multiplexed, active-low `an`/`seg`/`dp` lines driven to the board display and decodes them back into a 16-bit hex value plus per-digit blank and decimal-point flags. Used in loopback self-test of the FIR display path: the filter output is shown on the display, and this block recovers it for comparison without a separate debug port. Each digit is qualified by a stability counter. Results are published once per complete 4-digit frame.

---
 rtl/sseg_capture.sv | 163 ++++++++++++++++
 tb/tb_sseg_capture.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// Seven-segment bus receiver: watches the multiplexed active-low an/seg/dp lines,
// qualifies each digit by stability, and publishes a decoded 4-digit frame.
module sseg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:6]  seg,
    input  logic        dp,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  blank_mask,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        pattern_err
);

    // The commit edge is the one where cnt moves from STABLE_CYCLES-2 to STABLE_CYCLES-1.
    localparam logic [7:0] CNT_PRE_COMMIT = 8'(STABLE_CYCLES - 2);

    logic [11:0] in_d, in_q;
    logic [7:0]  cnt_d, cnt_q;
    logic        one_hot, stable, commit, commit_ok, frame_done;
    logic [3:0]  nibble;
    logic        known, is_blank;

    logic [15:0] work_val;
    logic [3:0]  work_blank, work_dp, captured;

    logic [15:0] value_d, value_q;
    logic [3:0]  blank_mask_d, blank_mask_q;
    logic [3:0]  dp_mask_d, dp_mask_q;
    logic        frame_valid_d, frame_valid_q;
    logic        pattern_err_d, pattern_err_q;

    always_comb begin
        in_d    = {an, seg, dp};
        one_hot = (an == 4'b1110) || (an == 4'b1101) ||
                  (an == 4'b1011) || (an == 4'b0111);
        stable  = one_hot && (in_d == in_q);
        cnt_d   = 8'd0;
        if (stable) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
        commit  = stable && (cnt_q == CNT_PRE_COMMIT);
    end

    always_comb begin
        known    = 1'b1;
        is_blank = 1'b0;
        nibble   = 4'h0;
        case (seg)
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b1100000: nibble = 4'hB;
            7'b0110001: nibble = 4'hC;
            7'b1000010: nibble = 4'hD;
            7'b0110000: nibble = 4'hE;
            7'b0111000: nibble = 4'hF;
            7'b1111111: begin
                known    = 1'b0;
                is_blank = 1'b1;
            end
            default:    known = 1'b0;
        endcase
        commit_ok  = commit && (known || is_blank);
        frame_done = &captured;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] val_d, val_q;
            logic       blank_d, blank_q, wdp_d, wdp_q, cap_d, cap_q;

            always_comb begin
                val_d   = val_q;
                blank_d = blank_q;
                wdp_d   = wdp_q;
                cap_d   = cap_q;
                if (frame_done) begin
                    cap_d = 1'b0;
                end
                // an is one-hot-low whenever commit is set, so an[gi] low selects this digit.
                if (commit_ok && !an[gi]) begin
                    val_d   = nibble;
                    blank_d = is_blank;
                    wdp_d   = ~dp;
                    cap_d   = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_q   <= 4'h0;
                    blank_q <= 1'b0;
                    wdp_q   <= 1'b0;
                    cap_q   <= 1'b0;
                end else begin
                    val_q   <= val_d;
                    blank_q <= blank_d;
                    wdp_q   <= wdp_d;
                    cap_q   <= cap_d;
                end
            end

            assign work_val[4*gi +: 4] = val_q;
            assign work_blank[gi]      = blank_q;
            assign work_dp[gi]         = wdp_q;
            assign captured[gi]        = cap_q;
        end
    endgenerate

    always_comb begin
        value_d       = value_q;
        blank_mask_d  = blank_mask_q;
        dp_mask_d     = dp_mask_q;
        frame_valid_d = 1'b0;
        pattern_err_d = commit && !known && !is_blank;
        if (frame_done) begin
            value_d       = work_val;
            blank_mask_d  = work_blank;
            dp_mask_d     = work_dp;
            frame_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q          <= '1;
            cnt_q         <= 8'd0;
            value_q       <= 16'h0000;
            blank_mask_q  <= 4'h0;
            dp_mask_q     <= 4'h0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            in_q          <= in_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            blank_mask_q  <= blank_mask_d;
            dp_mask_q     <= dp_mask_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
        end
    end

    assign value       = value_q;
    assign blank_mask  = blank_mask_q;
    assign dp_mask     = dp_mask_q;
    assign frame_valid = frame_valid_q;
    assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Scoreboard bench for sseg_capture: stimulus pushes expected frames, a monitor
// pops and compares them whenever frame_valid pulses.
module tb_sseg_capture;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100, PA = 7'b0001000, PB = 7'b1100000;
    localparam logic [6:0] PC = 7'b0110001, PD = 7'b1000010, PE = 7'b0110000;
    localparam logic [6:0] PF = 7'b0111000, PBLANK = 7'b1111111, PBAD = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  blank_mask, dp_mask;
    logic        frame_valid, pattern_err;

    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    logic        fv_prev = 1'b0;
    logic [23:0] exp_q[$];

    sseg_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .an(an),
        .value(value), .blank_mask(blank_mask), .dp_mask(dp_mask),
        .frame_valid(frame_valid), .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic show(input int d, input logic [6:0] p, input logic dpv, input int n);
        an  = ~(4'b0001 << d);
        seg = p;
        dp  = dpv;
        repeat (n) @(negedge clk);
    endtask

    task automatic raw_an(input logic [3:0] a, input int n);
        an = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an  = 4'hF;
        seg = '1;
        dp  = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: outputs only move on posedge, so negedge sampling is race-free.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n) begin
            if (pattern_err) err_pulses++;
            if (frame_valid) begin
                check("frame_valid_gap", 32'(fv_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame value=%h blank=%b dp=%b", value, blank_mask, dp_mask);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_value", 32'(value), 32'(e[23:8]));
                    check("frame_blank", 32'(blank_mask), 32'(e[7:4]));
                    check("frame_dp", 32'(dp_mask), 32'(e[3:0]));
                end
            end
            fv_prev = frame_valid;
        end else begin
            fv_prev = 1'b0;
        end
    end

    initial begin
        an = 4'hF; seg = '1; dp = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_value", 32'(value), 32'h0);
        check("reset_masks", 32'({blank_mask, dp_mask}), 32'h0);
        check("reset_pulses", 32'({frame_valid, pattern_err}), 32'h0);
        rst_n = 1'b1;
        idle(3);

        // Basic scan 4,3,2,1 on digits 0..3.
        exp_q.push_back({16'h1234, 4'h0, 4'h0});
        show(0, P4, 1'b1, 10); show(1, P3, 1'b1, 10);
        show(2, P2, 1'b1, 10); show(3, P1, 1'b1, 10);
        idle(4);

        // Hex letters with the decimal point lit on digit 2.
        exp_q.push_back({16'hDCBA, 4'h0, 4'b0100});
        show(0, PA, 1'b1, 10); show(1, PB, 1'b1, 10);
        show(2, PC, 1'b0, 10); show(3, PD, 1'b1, 10);
        idle(4);
        check("no_err_letters", 32'(err_pulses), 32'd0);

        // Blank digit 3.
        exp_q.push_back({16'h00F8, 4'b1000, 4'h0});
        show(0, P8, 1'b1, 10); show(1, PF, 1'b1, 10);
        show(2, P0, 1'b1, 10); show(3, PBLANK, 1'b1, 10);
        idle(4);

        // Too-short dwell with ghosting transitions: no frame may appear.
        for (int r = 0; r < 2; r++) begin
            show(0, P5, 1'b1, 3); raw_an(4'b0000, 1); raw_an(4'b1100, 1);
            show(1, P6, 1'b1, 3); raw_an(4'b0000, 1); raw_an(4'b1100, 1);
            show(2, P7, 1'b1, 3); raw_an(4'b0000, 1); raw_an(4'b1100, 1);
            show(3, P9, 1'b1, 3); raw_an(4'b0000, 1); raw_an(4'b1100, 1);
        end
        idle(4);
        check("short_dwell_value_held", 32'(value), 32'h00F8);
        exp_q.push_back({16'h9765, 4'h0, 4'h0});
        show(0, P5, 1'b1, 4); show(1, P6, 1'b1, 4);
        show(2, P7, 1'b1, 4); show(3, P9, 1'b1, 4);
        idle(4);

        // Undecodable digit 1 blocks the frame until a valid digit 1 arrives.
        show(0, PE, 1'b1, 10); show(1, PBAD, 1'b1, 10);
        show(2, P8, 1'b1, 10); show(3, P0, 1'b1, 10);
        idle(4);
        check("pattern_err_count", 32'(err_pulses), 32'd1);
        exp_q.push_back({16'h083E, 4'h0, 4'h0});
        show(1, P3, 1'b1, 10);
        idle(4);

        // Reset after two committed digits discards the partial frame.
        show(0, P1, 1'b1, 10); show(1, P2, 1'b1, 10);
        rst_n = 1'b0;
        #1;
        check("midreset_value", 32'(value), 32'h0);
        check("midreset_masks", 32'({blank_mask, dp_mask, frame_valid, pattern_err}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        show(2, P5, 1'b1, 10); show(3, P6, 1'b1, 10);
        idle(4);
        exp_q.push_back({16'h6587, 4'h0, 4'h0});
        show(0, P7, 1'b1, 10); show(1, P8, 1'b1, 10);
        idle(4);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("pattern_err_total", 32'(err_pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
